// File: rtl/uart_alu_if.sv
// ----------------------------------------------------------------------------
// uart_alu_if
//
// Sequencer that sits between the UART receiver/transmitter and the
// combinational ALU. It collects three received bytes (operand A, operand B,
// opcode) and drives them to the ALU. It then captures the ALU result and
// hands that result to the UART transmitter as a single byte. Unsupported
// opcodes are rejected with a one-cycle error pulse.
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous reset, active-high
//   i_rx_done    one-cycle pulse from UART rx, i_rx_data valid
//   i_rx_data    received byte
//   i_tx_done    one-cycle pulse from UART tx, stop bit finished
//   i_alu_result combinational ALU output
//   o_data_a     operand A to ALU
//   o_data_b     operand B to ALU
//   o_op_code    opcode to ALU (low NB_CODE bits of the opcode byte)
//   o_tx_start   one-cycle pulse to UART tx
//   o_tx_data    byte to transmit, stable from o_tx_start until i_tx_done
//   o_busy       high while executing, sending or waiting for the transmitter
//   o_err        one-cycle pulse on an invalid opcode
// ----------------------------------------------------------------------------
module uart_alu_if #(
  parameter int NB_DATA  = 8,
  parameter int NB_CODE  = 6,
  parameter int NB_STATE = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_CODE-1:0] o_op_code,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_err
);

  typedef enum logic [NB_STATE-1:0] {
    ST_WAIT_A  = NB_STATE'(0),
    ST_WAIT_B  = NB_STATE'(1),
    ST_WAIT_OP = NB_STATE'(2),
    ST_EXEC    = NB_STATE'(3),
    ST_SEND    = NB_STATE'(4),
    ST_WAIT_TX = NB_STATE'(5)
  } state_t;

  localparam logic [NB_CODE-1:0] OP_ADD = NB_CODE'(6'b100000);
  localparam logic [NB_CODE-1:0] OP_SUB = NB_CODE'(6'b100010);
  localparam logic [NB_CODE-1:0] OP_AND = NB_CODE'(6'b100100);
  localparam logic [NB_CODE-1:0] OP_OR  = NB_CODE'(6'b100101);
  localparam logic [NB_CODE-1:0] OP_XOR = NB_CODE'(6'b100110);
  localparam logic [NB_CODE-1:0] OP_NOR = NB_CODE'(6'b100111);
  localparam logic [NB_CODE-1:0] OP_SRA = NB_CODE'(6'b000011);
  localparam logic [NB_CODE-1:0] OP_SRL = NB_CODE'(6'b000010);

  state_t state;

  function automatic logic is_valid_op(input logic [NB_CODE-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // NOTE: every register here, including the operand/result data, is cleared
  // by reset. The data registers feed the ALU directly, so a known value
  // avoids propagating X into the result path.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_WAIT_A;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op_code  <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout. The pulse outputs default
      // low here and are only raised by the one branch that needs them.
      o_tx_start <= 1'b0;
      o_err      <= 1'b0;

      case (state)
        ST_WAIT_A: begin
          if (i_rx_done) begin
            o_data_a <= i_rx_data;
            state    <= ST_WAIT_B;
          end
        end

        ST_WAIT_B: begin
          if (i_rx_done) begin
            o_data_b <= i_rx_data;
            state    <= ST_WAIT_OP;
          end
        end

        ST_WAIT_OP: begin
          if (i_rx_done) begin
            o_op_code <= i_rx_data[NB_CODE-1:0];
            if (is_valid_op(i_rx_data[NB_CODE-1:0])) begin
              o_busy <= 1'b1;
              state  <= ST_EXEC;
            end else begin
              o_err <= 1'b1;
              state <= ST_WAIT_A;
            end
          end
        end

        // The opcode register updated on entry, so the ALU has had a full
        // cycle to settle. Raising tx_start here makes it visible exactly in
        // the SEND cycle.
        ST_EXEC: begin
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          state      <= ST_SEND;
        end

        ST_SEND: begin
          state <= ST_WAIT_TX;
        end

        // A byte that arrives here (even in the same cycle as tx_done) is
        // dropped, so the next frame always starts clean in WAIT_A.
        ST_WAIT_TX: begin
          if (i_tx_done) begin
            o_busy <= 1'b0;
            state  <= ST_WAIT_A;
          end
        end

        default: begin
          o_busy <= 1'b0;
          state  <= ST_WAIT_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_if.sv
// ----------------------------------------------------------------------------
// tb_uart_alu_if
//
// Directed testbench for uart_alu_if. The UART rx/tx pulses are driven by
// tasks and the ALU is a small behavioural model. Expected values are hand
// computed. Inputs change on the falling edge and outputs are sampled on
// the falling edge.
// ----------------------------------------------------------------------------
module tb_uart_alu_if;

  localparam int NB_DATA  = 8;
  localparam int NB_CODE  = 6;
  localparam int NB_STATE = 4;

  logic               i_clk;
  logic               i_reset;
  logic               i_rx_done;
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_tx_done;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_CODE-1:0] o_op_code;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_busy;
  logic               o_err;

  int checks = 0;
  int errors = 0;

  // Monitor state: cycle count, pulse counts, rx_done to tx_start distance.
  int cyc         = 0;
  int last_rx_cyc = 0;
  int tx_starts   = 0;
  int err_pulses  = 0;
  int tx_lat      = -1;

  uart_alu_if #(
    .NB_DATA  (NB_DATA),
    .NB_CODE  (NB_CODE),
    .NB_STATE (NB_STATE)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rx_done    (i_rx_done),
    .i_rx_data    (i_rx_data),
    .i_tx_done    (i_tx_done),
    .i_alu_result (i_alu_result),
    .o_data_a     (o_data_a),
    .o_data_b     (o_data_b),
    .o_op_code    (o_op_code),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_busy       (o_busy),
    .o_err        (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural ALU.
  always_comb begin
    i_alu_result = '0;
    case (o_op_code)
      6'b100000: i_alu_result = o_data_a + o_data_b;
      6'b100010: i_alu_result = o_data_a - o_data_b;
      6'b100100: i_alu_result = o_data_a & o_data_b;
      6'b100101: i_alu_result = o_data_a | o_data_b;
      6'b100110: i_alu_result = o_data_a ^ o_data_b;
      6'b100111: i_alu_result = ~(o_data_a | o_data_b);
      6'b000011: i_alu_result = NB_DATA'($signed(o_data_a) >>> o_data_b);
      6'b000010: i_alu_result = o_data_a >> o_data_b;
      default:   i_alu_result = '0;
    endcase
  end

  always @(posedge i_clk) begin
    cyc = cyc + 1;
    if (i_rx_done) last_rx_cyc = cyc;
    if (o_tx_start) begin
      tx_starts = tx_starts + 1;
      tx_lat    = cyc - last_rx_cyc;
    end
    if (o_err) err_pulses = err_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clk);
    i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done(input logic with_rx, input logic [7:0] b);
    @(negedge i_clk);
    i_tx_done = 1'b1;
    i_rx_done = with_rx;
    i_rx_data = b;
    @(negedge i_clk);
    i_tx_done = 1'b0;
    i_rx_done = 1'b0;
  endtask

  task automatic wait_tx_start(input string tag);
    int n = 0;
    while (!o_tx_start && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check({tag, "_tx_start_seen"}, 32'(o_tx_start), 32'd1);
  endtask

  // Full valid frame. The caller finishes it with pulse_tx_done.
  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] res);
    int starts0 = tx_starts;
    send_byte(a);
    send_byte(b);
    send_byte(op);
    check({tag, "_busy_exec"}, 32'(o_busy), 32'd1);
    check({tag, "_op_code"}, 32'(o_op_code), 32'(op[5:0]));
    wait_tx_start(tag);
    check({tag, "_tx_data"}, 32'(o_tx_data), 32'(res));
    @(negedge i_clk);
    check({tag, "_tx_start_width"}, 32'(o_tx_start), 32'd0);
    check({tag, "_tx_start_count"}, 32'(tx_starts - starts0), 32'd1);
    check({tag, "_latency"}, 32'(tx_lat), 32'd2);
    check({tag, "_tx_data_hold"}, 32'(o_tx_data), 32'(res));
    check({tag, "_busy_wait_tx"}, 32'(o_busy), 32'd1);
  endtask

  task automatic finish_frame(input string tag);
    pulse_tx_done(1'b0, 8'h00);
    check({tag, "_busy_idle"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int starts0;
    int errs0;

    i_reset   = 1'b1;
    i_rx_done = 1'b0;
    i_rx_data = '0;
    i_tx_done = 1'b0;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;

    check("rst_data_a",   32'(o_data_a),   32'd0);
    check("rst_data_b",   32'(o_data_b),   32'd0);
    check("rst_op_code",  32'(o_op_code),  32'd0);
    check("rst_tx_data",  32'(o_tx_data),  32'd0);
    check("rst_tx_start", 32'(o_tx_start), 32'd0);
    check("rst_busy",     32'(o_busy),     32'd0);
    check("rst_err",      32'(o_err),      32'd0);

    // tx_done while idle is ignored.
    pulse_tx_done(1'b0, 8'h00);
    check("idle_tx_done_busy", 32'(o_busy), 32'd0);

    run_frame("add", 8'h03, 8'h08, 8'h20, 8'h0B);
    finish_frame("add");

    run_frame("sub", 8'h0A, 8'h03, 8'h22, 8'h07);
    finish_frame("sub");

    run_frame("sra", 8'h80, 8'h01, 8'h03, 8'hC0);
    finish_frame("sra");

    run_frame("srl", 8'h80, 8'h01, 8'h02, 8'h40);
    finish_frame("srl");

    run_frame("nor", 8'hF0, 8'h0C, 8'h27, 8'h03);
    finish_frame("nor");

    // Invalid opcode.
    starts0 = tx_starts;
    errs0   = err_pulses;
    send_byte(8'h05);
    send_byte(8'h06);
    send_byte(8'h3F);
    check("inv_err_high", 32'(o_err), 32'd1);
    check("inv_busy", 32'(o_busy), 32'd0);
    repeat (5) @(negedge i_clk);
    check("inv_err_count", 32'(err_pulses - errs0), 32'd1);
    check("inv_no_tx_start", 32'(tx_starts - starts0), 32'd0);
    check("inv_data_a_kept", 32'(o_data_a), 32'h05);
    check("inv_data_b_kept", 32'(o_data_b), 32'h06);
    run_frame("after_inv", 8'h01, 8'h01, 8'h20, 8'h02);
    finish_frame("after_inv");

    // Upper opcode bits ignored: 0xE0 acts as ADD.
    run_frame("upper", 8'h04, 8'h05, 8'hE0, 8'h09);
    finish_frame("upper");

    // Bytes while busy: a lone rx in WAIT_TX, then rx together with tx_done.
    run_frame("busy", 8'h10, 8'h20, 8'h25, 8'h30);
    send_byte(8'h55);
    check("busy_rx_ignored", 32'(o_busy), 32'd1);
    pulse_tx_done(1'b1, 8'h77);
    check("busy_rx_tx_same", 32'(o_busy), 32'd0);
    run_frame("after_busy", 8'h02, 8'h02, 8'h20, 8'h04);
    check("after_busy_a", 32'(o_data_a), 32'h02);
    finish_frame("after_busy");

    // Reset mid-frame.
    send_byte(8'h11);
    send_byte(8'h22);
    check("mid_data_b", 32'(o_data_b), 32'h22);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    check("mid_rst_data_a",  32'(o_data_a),  32'd0);
    check("mid_rst_data_b",  32'(o_data_b),  32'd0);
    check("mid_rst_op_code", 32'(o_op_code), 32'd0);
    check("mid_rst_tx_data", 32'(o_tx_data), 32'd0);
    check("mid_rst_busy",    32'(o_busy),    32'd0);
    run_frame("after_rst", 8'h01, 8'h02, 8'h20, 8'h03);
    finish_frame("after_rst");

    // Reset while tx_start is pending in EXEC cancels the pulse.
    starts0 = tx_starts;
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h20);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    check("cancel_no_tx_start", 32'(tx_starts - starts0), 32'd0);
    check("cancel_busy", 32'(o_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
